// File: rtl/line_buffer_3x3.sv
// Streaming 3x3 window generator: buffers two raster lines and emits every
// fully-inside 3x3 neighbourhood with single-register backpressure.
module line_buffer_3x3 #(
    parameter int IMG_WIDTH  = 16,
    parameter int IMG_HEIGHT = 16,
    parameter int DATA_W     = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_W-1:0]             in_pixel,
    input  logic                          in_sof,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [2:0][2:0][DATA_W-1:0]   out_patch,
    output logic                          out_last
);

    localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_TWO = CW'(2);
    localparam logic [RW-1:0] ROW_TWO = RW'(2);

    logic [DATA_W-1:0]           lineA_q [IMG_WIDTH];
    logic [DATA_W-1:0]           lineB_q [IMG_WIDTH];

    logic [CW-1:0]               col_q, col_d, colCur;
    logic [RW-1:0]               row_q, row_d, rowCur;
    logic [2:0][2:0][DATA_W-1:0] win_q, win_d;
    logic                        valid_q, valid_d;
    logic                        last_q, last_d;
    logic                        accept;

    assign in_ready  = !valid_q || out_ready;
    assign accept    = in_valid && in_ready;
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign out_patch = win_q;

    // A start-of-frame beat is placed at (0,0) no matter where the counters are.
    always_comb begin
        colCur  = in_sof ? '0 : col_q;
        rowCur  = in_sof ? '0 : row_q;
        col_d   = col_q;
        row_d   = row_q;
        win_d   = win_q;
        valid_d = valid_q;
        last_d  = last_q;
        if (accept) begin
            if (colCur == COL_MAX) begin
                col_d = '0;
                row_d = (rowCur == ROW_MAX) ? '0 : rowCur + 1'b1;
            end else begin
                col_d = colCur + 1'b1;
                row_d = rowCur;
            end
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = lineA_q[colCur];
            win_d[1][2] = lineB_q[colCur];
            win_d[2][2] = in_pixel;
            valid_d     = (rowCur >= ROW_TWO) && (colCur >= COL_TWO);
            last_d      = (rowCur == ROW_MAX) && (colCur == COL_MAX);
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q   <= '0;
            row_q   <= '0;
            win_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            win_q   <= win_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    // Line memories carry no reset; rows 0 and 1 of every frame overwrite them before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            lineA_q[colCur] <= lineB_q[colCur];
            lineB_q[colCur] <= in_pixel;
        end
    end

endmodule

// File: tb/tb_line_buffer_3x3.sv
// Self-checking bench for line_buffer_3x3: directed frames plus randomized
// traffic compared against an image-array reference model.
module tb_line_buffer_3x3;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int DW = 8;
    localparam int PW = 9 * DW;

    logic                    clk;
    logic                    rst_n;
    logic                    in_valid;
    logic                    in_ready;
    logic [DW-1:0]           in_pixel;
    logic                    in_sof;
    logic                    out_valid;
    logic                    out_ready;
    logic [2:0][2:0][DW-1:0] out_patch;
    logic                    out_last;

    line_buffer_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pixel  (in_pixel),
        .in_sof    (in_sof),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_patch (out_patch),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [PW-1:0] patch;
        logic          last;
    } win_t;

    int            compareCount  = 0;
    int            mismatchCount = 0;
    win_t          expQ[$];
    logic [DW-1:0] img [H][W];
    int            mRow = 0;
    int            mCol = 0;
    logic [PW-1:0] gotPatch [256];
    logic          gotLast  [256];
    int            gotCount    = 0;
    int            stallCycles = 0;
    logic          stallPrev   = 1'b0;
    logic [PW-1:0] heldPatch   = '0;
    int            readyMode   = 0;
    int            stallAt     = -1;
    int            stallCnt    = 0;

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Window whose top-left pixel is t in an image filled with t, t+1, ... in raster order.
    function automatic logic [PW-1:0] mkPatch(input int t);
        logic [PW-1:0] p;
        p = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                p[(r*3+c)*DW +: DW] = DW'(t + W*r + c);
        return p;
    endfunction

    // Reference model: stores each pixel at its (row,col) and cuts windows from the image.
    always @(negedge clk) begin
        if (!rst_n) begin
            expQ.delete();
            mRow      = 0;
            mCol      = 0;
            stallPrev = 1'b0;
        end else begin
            checkOutput("in_ready", in_ready, !out_valid || out_ready);
            checkOutput("out_valid", out_valid, expQ.size() != 0);
            if (stallPrev) checkOutput("stallHold", out_patch, heldPatch);
            if (out_valid && !out_ready) stallCycles++;
            if (out_valid && out_ready && expQ.size() != 0) begin
                checkOutput("patch", out_patch, expQ[0].patch);
                checkOutput("last", out_last, expQ[0].last);
                gotPatch[gotCount & 255] = out_patch;
                gotLast[gotCount & 255]  = out_last;
                gotCount++;
                void'(expQ.pop_front());
            end
            stallPrev = out_valid && !out_ready;
            heldPatch = out_patch;
            if (in_valid && in_ready) begin
                win_t w;
                if (in_sof) begin
                    mRow = 0;
                    mCol = 0;
                end
                img[mRow][mCol] = in_pixel;
                if (mRow >= 2 && mCol >= 2) begin
                    w.patch = '0;
                    for (int r = 0; r < 3; r++)
                        for (int c = 0; c < 3; c++)
                            w.patch[(r*3+c)*DW +: DW] = img[mRow-2+r][mCol-2+c];
                    w.last = (mRow == H-1) && (mCol == W-1);
                    expQ.push_back(w);
                end
                mCol++;
                if (mCol == W) begin
                    mCol = 0;
                    mRow = (mRow + 1) % H;
                end
            end
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                1: out_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (out_valid && gotCount == stallAt && stallCnt < 3) begin
                        out_ready = 1'b0;
                        stallCnt++;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                default: out_ready = 1'b1;
            endcase
        end
    end

    task automatic applyStimulus(input logic [DW-1:0] pix, input logic sof, input int gap);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_pixel = pix;
        in_sof   = sof;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
        end
        if (!done) checkOutput("acceptTimeout", 0, 1);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        for (int g = 0; g < gap; g++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sendFrame(input int base, input logic sofFirst, input int gap);
        for (int i = 0; i < W*H; i++)
            applyStimulus(DW'(base + i), sofFirst && (i == 0), gap);
    endtask

    task automatic waitDrain();
        for (int t = 0; t < 200 && (expQ.size() != 0 || out_valid); t++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("drain", expQ.size(), 0);
    endtask

    initial begin
        int s;
        int st0;
        int tl[4];
        tl = '{1, 2, 5, 6};
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_pixel = '0;
        in_sof   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstValid", out_valid, 0);
        checkOutput("rstLast", out_last, 0);
        checkOutput("rstPatch", out_patch, 0);
        checkOutput("rstReady", in_ready, 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] single 4x4 frame");
        s = gotCount;
        sendFrame(1, 1'b1, 0);
        waitDrain();
        checkOutput("t1Count", gotCount - s, 4);
        for (int k = 0; k < 4; k++) begin
            checkOutput("t1Patch", gotPatch[(s+k) & 255], mkPatch(tl[k]));
            checkOutput("t1Last", gotLast[(s+k) & 255], k == 3);
        end

        $display("[TB] stall on second window");
        s         = gotCount;
        stallAt   = s + 1;
        st0       = stallCycles;
        readyMode = 2;
        sendFrame(1, 1'b1, 0);
        waitDrain();
        readyMode = 0;
        checkOutput("t2StallCycles", stallCycles - st0, 3);
        checkOutput("t2Count", gotCount - s, 4);
        for (int k = 0; k < 4; k++)
            checkOutput("t2Patch", gotPatch[(s+k) & 255], mkPatch(tl[k]));

        $display("[TB] two frames back-to-back");
        s = gotCount;
        sendFrame(1, 1'b1, 0);
        sendFrame(101, 1'b0, 0);
        waitDrain();
        checkOutput("t3Count", gotCount - s, 8);
        checkOutput("t3F2First", gotPatch[(s+4) & 255], mkPatch(101));
        checkOutput("t3F2Last", gotPatch[(s+7) & 255], mkPatch(106));

        $display("[TB] sof restart on 7th pixel");
        s = gotCount;
        for (int i = 0; i < 6; i++) applyStimulus(DW'(201 + i), i == 0, 0);
        sendFrame(1, 1'b1, 0);
        waitDrain();
        checkOutput("t4Count", gotCount - s, 4);
        checkOutput("t4First", gotPatch[s & 255], mkPatch(1));

        $display("[TB] asynchronous reset mid-frame");
        for (int i = 0; i < 11; i++) applyStimulus(DW'(1 + i), i == 0, 0);
        checkOutput("t5PreRstValid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("t5RstValid", out_valid, 0);
        checkOutput("t5RstLast", out_last, 0);
        checkOutput("t5RstPatch", out_patch, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        s = gotCount;
        sendFrame(1, 1'b0, 0);
        waitDrain();
        checkOutput("t5Count", gotCount - s, 4);
        for (int k = 0; k < 4; k++)
            checkOutput("t5Patch", gotPatch[(s+k) & 255], mkPatch(tl[k]));

        $display("[TB] in_valid toggling");
        s = gotCount;
        sendFrame(1, 1'b1, 1);
        waitDrain();
        checkOutput("t6Count", gotCount - s, 4);
        for (int k = 0; k < 4; k++) begin
            checkOutput("t6Patch", gotPatch[(s+k) & 255], mkPatch(tl[k]));
            checkOutput("t6Last", gotLast[(s+k) & 255], k == 3);
        end

        $display("[TB] randomized traffic");
        readyMode = 1;
        for (int f = 0; f < 8; f++)
            for (int i = 0; i < W*H; i++)
                applyStimulus(DW'($urandom_range(0, 255)),
                              (i == 0 && (f % 2) == 0) || (f == 3 && i == 5),
                              $urandom_range(0, 2));
        waitDrain();
        readyMode = 0;

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
